// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO result pair and busy/done handshake.
// Operands are captured at start. The result is computed from the captured copy and committed when the count expires.
module md_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       mdop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MSUB  = 3'd7;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic                   accept, finish;
  logic [2:0]             op_q;
  logic [WIDTH-1:0]       a_q, b_q;
  logic [2*WIDTH-1:0]     acc_q;
  logic [2*WIDTH-1:0]     result;

  logic [2*WIDTH-1:0]     sa_ext, sb_ext, ua_ext, ub_ext;
  logic [2*WIDTH-1:0]     prod_s, prod_u;
  logic signed [WIDTH-1:0] sa, sb, sq, sr;
  logic [WIDTH-1:0]       ones, min_neg;

  always_comb begin
    sa_ext  = {{WIDTH{a_q[WIDTH-1]}}, a_q};
    sb_ext  = {{WIDTH{b_q[WIDTH-1]}}, b_q};
    ua_ext  = {{WIDTH{1'b0}}, a_q};
    ub_ext  = {{WIDTH{1'b0}}, b_q};
    // Low 2*WIDTH bits of the sign-extended product are the exact signed product.
    prod_s  = sa_ext * sb_ext;
    prod_u  = ua_ext * ub_ext;
    sa      = a_q;
    sb      = b_q;
    sq      = sa / sb;
    sr      = sa % sb;
    ones    = {WIDTH{1'b1}};
    min_neg = {1'b1, {(WIDTH-1){1'b0}}};
    result  = acc_q;
    case (op_q)
      OP_MULT:  result = prod_s;
      OP_MULTU: result = prod_u;
      OP_MADD:  result = acc_q + prod_s;
      OP_MSUB:  result = acc_q - prod_s;
      OP_DIVU: begin
        if (b_q == '0) result = {a_q, ones};
        else           result = {a_q % b_q, a_q / b_q};
      end
      OP_DIV: begin
        if (b_q == '0)                           result = {a_q, ones};
        else if (a_q == min_neg && b_q == ones)  result = {{WIDTH{1'b0}}, a_q};
        else                                     result = {sr, sq};
      end
      default: result = acc_q;
    endcase
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start && mdop != OP_MTHI && mdop != OP_MTLO) begin
          accept    = 1'b1;
          state_nxt = RUN;
          cnt_nxt   = (mdop == OP_DIV || mdop == OP_DIVU) ? CW'(DIV_CYCLES - 1)
                                                          : CW'(MULT_CYCLES - 1);
        end
      end
      RUN: begin
        if (cnt == '0) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
    end else begin
      done <= finish;
      if (accept) begin
        op_q  <= mdop;
        a_q   <= a;
        b_q   <= b;
        acc_q <= {hi, lo};
      end
      if (finish) begin
        {hi, lo} <= result;
      end else if (state == IDLE && start) begin
        if (mdop == OP_MTHI) hi <= a;
        if (mdop == OP_MTLO) lo <= a;
      end
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: stimulus pushes expected {hi,lo} into a queue, a monitor checks on each done.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  mdop = 3'd0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];

  md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mdop(mdop), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done actual=1 required=0 hi=%h lo=%h", hi, lo);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("result_hi", hi, e[63:32]);
        check("result_lo", lo, e[31:0]);
      end
    end
  end

  // Called at a negedge; returns at the negedge where done is expected, so the next op goes back-to-back.
  task automatic op_mc(input logic [2:0] op, input logic [31:0] ia, input logic [31:0] ib,
                       input logic [31:0] eh, input logic [31:0] el, input int n, input bit inj);
    logic [31:0] oh, ol;
    oh = hi;
    ol = lo;
    start = 1'b1; mdop = op; a = ia; b = ib;
    exp_q.push_back({eh, el});
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      check("busy_run", {31'd0, busy}, 32'd1);
      check("hold_hi", hi, oh);
      check("hold_lo", lo, ol);
      if (inj && i == 1) begin start = 1'b1; mdop = 3'd5; a = 32'h55; end
      if (inj && i == 2) begin start = 1'b1; mdop = 3'd3; a = 32'd100; b = 32'd3; end
      if (inj && i == 3) start = 1'b0;
      a = $urandom; b = $urandom;
      @(negedge clk);
    end
    check("busy_end", {31'd0, busy}, 32'd0);
    check("done_end", {31'd0, done}, 32'd1);
  endtask

  task automatic op_mt(input logic [2:0] op, input logic [31:0] ia,
                       input logic [31:0] eh, input logic [31:0] el);
    start = 1'b1; mdop = op; a = ia;
    @(negedge clk);
    start = 1'b0;
    check("mt_busy", {31'd0, busy}, 32'd0);
    check("mt_hi", hi, eh);
    check("mt_lo", lo, el);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    #3;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    op_mc(3'd0, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 5, 0);
    op_mc(3'd3, 32'd7, 32'd2, 32'd1, 32'd3, 10, 0);
    op_mc(3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, 0);
    op_mc(3'd2, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 10, 0);
    op_mc(3'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 10, 0);
    op_mc(3'd3, 32'd9, 32'd0, 32'd9, 32'hFFFFFFFF, 10, 0);
    op_mc(3'd2, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, 10, 0);
    op_mc(3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5, 0);
    @(negedge clk);

    op_mt(3'd4, 32'd0, 32'd0, 32'd0);
    op_mt(3'd5, 32'd10, 32'd0, 32'd10);
    op_mc(3'd6, 32'd2, 32'd3, 32'd0, 32'd16, 5, 0);
    op_mc(3'd7, 32'd4, 32'd4, 32'd0, 32'd0, 5, 0);
    op_mc(3'd7, 32'd1, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 0);
    op_mc(3'd6, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFE, 5, 0);
    @(negedge clk);

    op_mc(3'd1, 32'hFFFFFFFF, 32'd2, 32'd1, 32'hFFFFFFFE, 5, 1);
    for (int i = 0; i < 12; i++) @(negedge clk);
    check("after_inj_lo", lo, 32'hFFFFFFFE);
    check("after_inj_busy", {31'd0, busy}, 32'd0);

    // Abandon a divide mid-run with an asynchronous reset.
    start = 1'b1; mdop = 3'd2; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_busy", {31'd0, busy}, 32'd0);
    check("async_hi", hi, 32'd0);
    check("async_lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) @(negedge clk);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("post_rst_lo", lo, 32'd0);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_done actual=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
